// File: rtl/rom_arb_pkg.sv
// Shared constants and types for the two-requester ROM burst arbiter.
package rom_arb_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              id;
    logic              last;
  } rsp_beat_t;

endpackage

// File: rtl/rom_burst_arbiter_if.sv
// Request, ROM and response bundle between the arbiter and its neighbours.
interface rom_burst_arbiter_if;
  import rom_arb_pkg::*;

  logic [1:0]        req_valid;
  logic [ADDR_W-1:0] req_addr0;
  logic [ADDR_W-1:0] req_addr1;
  logic [LEN_W-1:0]  req_len0;
  logic [LEN_W-1:0]  req_len1;
  logic [1:0]        req_ready;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_dout;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_id;
  logic              rsp_last;
  logic              busy;

  modport slave (
    input  req_valid, req_addr0, req_addr1, req_len0, req_len1, rom_dout,
    output req_ready, rom_addr, rsp_valid, rsp_data, rsp_id, rsp_last, busy
  );

  modport master (
    output req_valid, req_addr0, req_addr1, req_len0, req_len1, rom_dout,
    input  req_ready, rom_addr, rsp_valid, rsp_data, rsp_id, rsp_last, busy
  );

endinterface

// File: rtl/rr_arbiter_2.sv
// Two-input grant selection; round-robin by default, fixed priority to
// channel 0 when ROM_BURST_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic       grant_any,
  output logic       grant_id
);

  assign grant_any = |req;

`ifdef ROM_BURST_ARB_FIXED_PRIO_EN
  // Channel 0 wins whenever it is requesting.
  always_comb begin
    grant_id = 1'b0;
    if (req == 2'b10) begin
      grant_id = 1'b1;
    end else begin
      grant_id = 1'b0;
    end
  end
`else
  logic last_grant_r;

  // On a tie the channel that did not win last time is chosen.
  always_comb begin
    grant_id = 1'b0;
    case (req)
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~last_grant_r;
      default: grant_id = 1'b0;
    endcase
  end

  // Remember the most recent winner; resets to 1 so channel 0 takes the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_r <= 1'b1;
    end else if (update) begin
      last_grant_r <= grant_id;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end
`endif

endmodule

// File: rtl/rom_burst_arbiter.sv
// Shares a 1-cycle-latency ROM between two burst requesters and returns tagged beats.
// Optional build macro: ROM_BURST_ARB_FIXED_PRIO_EN (fixed priority to channel 0).
module rom_burst_arbiter
  import rom_arb_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  rom_burst_arbiter_if.slave  bus
);

  arb_state_t        state_r;
  logic [ADDR_W-1:0] cur_addr_r;
  logic [LEN_W-1:0]  cnt_r;
  logic              owner_r;
  logic [1:0]        req_ready_r;
  logic [ADDR_W-1:0] rom_addr_r;
  logic              busy_r;
  logic              issue_v_r;
  logic              issue_id_r;
  logic              issue_last_r;
  logic              rsp_valid_r;
  logic              rsp_id_r;
  logic              rsp_last_r;

  logic              grant_any_s;
  logic              grant_id_s;
  logic              grant_take_s;
  rsp_beat_t         rsp_beat_s;

  assign grant_take_s = (state_r == IDLE) && grant_any_s;

  rr_arbiter_2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (bus.req_valid),
    .update    (grant_take_s),
    .grant_any (grant_any_s),
    .grant_id  (grant_id_s)
  );

  // Burst sequencer plus the two-stage issue/response tag pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      cur_addr_r   <= {ADDR_W{1'b0}};
      cnt_r        <= {LEN_W{1'b0}};
      owner_r      <= 1'b0;
      req_ready_r  <= 2'b00;
      rom_addr_r   <= {ADDR_W{1'b0}};
      busy_r       <= 1'b0;
      issue_v_r    <= 1'b0;
      issue_id_r   <= 1'b0;
      issue_last_r <= 1'b0;
      rsp_valid_r  <= 1'b0;
      rsp_id_r     <= 1'b0;
      rsp_last_r   <= 1'b0;
    end else begin
      rsp_valid_r <= issue_v_r;
      rsp_id_r    <= issue_id_r;
      rsp_last_r  <= issue_last_r;
      case (state_r)
        IDLE: begin
          issue_v_r    <= 1'b0;
          issue_last_r <= 1'b0;
          if (grant_any_s) begin
            req_ready_r <= grant_id_s ? 2'b10 : 2'b01;
            cur_addr_r  <= grant_id_s ? bus.req_addr1 : bus.req_addr0;
            cnt_r       <= grant_id_s ? bus.req_len1 : bus.req_len0;
            owner_r     <= grant_id_s;
            busy_r      <= 1'b1;
            state_r     <= BURST;
          end else begin
            req_ready_r <= 2'b00;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end
        end
        BURST: begin
          req_ready_r  <= 2'b00;
          rom_addr_r   <= cur_addr_r;
          issue_v_r    <= 1'b1;
          issue_id_r   <= owner_r;
          issue_last_r <= (cnt_r == LEN_W'(0));
          if (cnt_r == LEN_W'(0)) begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            // Address wraps modulo the ROM depth by its width alone.
            cur_addr_r <= cur_addr_r + ADDR_W'(1);
            cnt_r      <= cnt_r - LEN_W'(1);
            busy_r     <= 1'b1;
            state_r    <= BURST;
          end
        end
        default: begin
          req_ready_r <= 2'b00;
          busy_r      <= 1'b0;
          issue_v_r   <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign rsp_beat_s = '{data: bus.rom_dout, id: rsp_id_r, last: rsp_last_r};

  assign bus.req_ready = req_ready_r;
  assign bus.rom_addr  = rom_addr_r;
  assign bus.busy      = busy_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_data  = rsp_beat_s.data;
  assign bus.rsp_id    = rsp_beat_s.id;
  assign bus.rsp_last  = rsp_beat_s.last;

endmodule

// File: doc/rom_burst_arbiter.md
Name: rom_burst_arbiter

Overview:
- Shares one 64x8 synchronous-read ROM (1-cycle registered read latency) between two requesters.
- Each requester posts a burst read: start address plus length. The block arbitrates round-robin, sequences consecutive ROM addresses, and returns tagged read data.
- Sits between the ROM instance and its consumers (for example, a table-lookup engine and a debug reader).

Parameters:
- ADDR_W, 6, ROM address width (64 words).
- DATA_W, 8, ROM data width.
- LEN_W, 4, burst length field width; a burst is req_len+1 beats (1..16).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  2  per-channel request valid.
- req_addr0, req_addr1  in  ADDR_W each  burst start address.
- req_len0, req_len1  in  LEN_W each  beats minus one.
- req_ready  out  2  one-cycle acceptance pulse, per channel.
- rom_addr  out  ADDR_W  address to ROM.
- rom_dout  in  DATA_W  ROM registered read data.
- rsp_valid  out  1  response beat valid.
- rsp_data  out  DATA_W  beat data (pass-through of rom_dout).
- rsp_id  out  1  channel owning the beat.
- rsp_last  out  1  final beat of the burst.
- busy  out  1  burst in progress (state BURST).

Behaviour:
- Reset values: state=IDLE, req_ready=0, rom_addr=0, rsp_valid=0, rsp_id=0, rsp_last=0, busy=0, cnt=0, last_grant=1 (so channel 0 wins the first tie).
- FSM states:
  - IDLE: if any req_valid, select a winner, pulse req_ready[winner] for that cycle, latch cur_addr=req_addrN, cnt=req_lenN, owner=winner, go to BURST. Otherwise stay in IDLE.
  - BURST: drive rom_addr=cur_addr. If cnt==0, go to IDLE; else cur_addr+=1 and cnt-=1.
- rom_addr is held at the last driven value while in IDLE.
- Arbitration:
  - Only one valid: that channel wins.
  - Both valid: the channel != last_grant wins.
  - last_grant updates on every grant.
- Requester rules:
  - Request fields must stay stable while req_valid is high until req_ready.
  - A request may be withdrawn only after it is accepted.
- Response pipeline: registers issue_v, issue_id, issue_last are set in each BURST cycle and drive rsp_valid, rsp_id, rsp_last one cycle later. rsp_data=rom_dout combinationally.
- Timing, with ready at cycle T:
  - Beat k address appears in cycle T+1+k.
  - Beat k response appears in cycle T+2+k.
  - rsp_last is high on beat N-1.
- Back-to-back bursts: a new grant is possible in the IDLE cycle right after BURST. This leaves one bubble cycle with rsp_valid low between bursts.
- Wrap-around: cur_addr is ADDR_W bits and wraps 63->0 silently.
- No response backpressure: consumers must accept every beat.
- Same-channel re-request: a request arriving while busy waits. A channel cannot win twice in a row while the other is waiting.
- Reset mid-burst: asynchronously aborts the burst. No further rsp_valid occurs for the aborted burst, including the in-flight beat.

Optional Feature:
- Macro ROM_BURST_ARB_FIXED_PRIO_EN.
- Defined: channel 0 always wins ties; last_grant is unused.
- Undefined: round-robin as described above.

Decomposition:
- Package rom_arb_pkg: ADDR_W, DATA_W, LEN_W constants; state enum typedef (IDLE, BURST); response beat struct (data, id, last).
- Sub-module rr_arbiter_2: 2-input grant logic with last_grant register and the fixed-priority macro hook.

Test Plan:
- Single burst, ROM model preloaded mem[i]=i: ch0 addr=0x05, len=3 → req_ready[0] at T; rsp beats 0x05..0x08 at T+2..T+5, id=0, rsp_last only on 0x08; busy high for 4 cycles.
- Wrap: ch1 addr=0x3E, len=3 → data 0x3E, 0x3F, 0x00, 0x01, id=1.
- Contention: both valid at the same cycle after reset, ch0 len=1, ch1 len=0 → ch0 served first (0x00..0x01 from its addr=0); ch1 accepted in the next IDLE with exactly one bubble cycle; held-high ch0 re-request is served after ch1. With ROM_BURST_ARB_FIXED_PRIO_EN, ch0 is served twice before ch1.
- Max length: len=15 from addr=0x10 → 16 beats 0x10..0x1F, last on 0x1F.
- Reset mid-burst: assert rst during beat 2 of a len=7 burst → all outputs 0 immediately, no further rsp_valid; a post-reset request is served normally with ch0 winning a tie.
- Idle stability: no req_valid for 20 cycles → rsp_valid=0, req_ready=0, busy=0 throughout.
